if_fetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline registers.
- Owns the PC, issues word requests to an instruction memory with a valid/ready request channel and in-order responses, and buffers returned instructions with their PCs in a small FIFO.
- Presents buffered instructions to the IF/ID stage with a valid/ready handshake; ready is the IF/ID write enable (not stall).
- Accepts redirects (taken branch, jal, jalr) from EX and discards all wrong-path work.

---
 rtl/if_fetch_queue.sv | 97 +++++++++
 tb/tb_if_fetch_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues in-order word fetches under a
// credit limit, and buffers returned instructions with their PCs for IF/ID.
module if_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam int          PW      = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]             fetch_pc, rsp_pc;
    logic [CW-1:0]           count, outstanding, drop_cnt;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [DEPTH-1:0][31:0]  pc_q, data_q;

    logic          req_fire, enq, deq;
    logic [CW-1:0] outstanding_nxt;
    logic [31:0]   target_pc;
    logic          unused_redirect_bits;

    assign target_pc            = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_bits = ^redirect_pc[1:0];

    // Credit counts buffered entries plus requests in flight, so every response
    // has a FIFO slot waiting; a same-cycle dequeue is deliberately not credited.
    assign imem_req_valid = !rst && !redirect_valid &&
                            (({1'b0, count} + {1'b0, outstanding}) < DEPTH_C);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign enq        = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
    assign inst_valid = (count != '0) && !redirect_valid;
    assign deq        = inst_valid && inst_ready;
    assign inst_pc    = pc_q[rd_ptr];
    assign inst_data  = data_q[rd_ptr];

    assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                // Everything still in flight is wrong-path; the response landing
                // this cycle is already excluded from outstanding_nxt.
                fetch_pc <= target_pc;
                rsp_pc   <= target_pc;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                drop_cnt <= outstanding_nxt;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + 32'd4;
                if (imem_rsp_valid && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - 1'b1;
                if (enq) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (deq)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(enq) - CW'(deq);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            pc_q[wr_ptr]   <= rsp_pc;
            data_q[wr_ptr] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with an in-order variable-latency memory model.
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        inst_valid;
    logic [31:0] inst_pc, inst_data;
    logic        inst_ready = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    int checks = 0;
    int errors = 0;

    if_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_pc(inst_pc), .inst_data(inst_data),
        .inst_ready(inst_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    // Memory model: in-order, fixed latency lat (>=1); data word = ~address.
    int          lat = 1;
    int          cyc = 0;
    logic [31:0] pend_addr [64];
    int          pend_due  [64];
    logic [5:0]  head = '0, tail = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (imem_rsp_valid) head <= head + 1'b1;
            if (imem_req_valid && imem_req_ready) begin
                pend_addr[tail] <= imem_req_addr;
                pend_due[tail]  <= cyc + lat;
                tail            <= tail + 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (head != tail && pend_due[head] <= cyc) begin
            imem_rsp_valid <= 1'b1;
            imem_rsp_data  <= ~pend_addr[head];
        end else begin
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end
    end

    // Delivery log and request counter.
    logic [31:0] log_pc   [256];
    logic [31:0] log_data [256];
    int n_log = 0;
    int n_req = 0;

    always @(posedge clk) begin
        if (!rst && inst_valid && inst_ready) begin
            log_pc[n_log[7:0]]   <= inst_pc;
            log_data[n_log[7:0]] <= inst_data;
            n_log <= n_log + 1;
        end
        if (!rst && imem_req_valid && imem_req_ready)
            n_req <= n_req + 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Reset for one cycle; returns at the start of the first post-reset cycle.
    task automatic pulse_reset();
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
    endtask

    task automatic test_reset();
        lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0;
        tick(); rst = 1'b1;
        tick(); #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got %b want 0", inst_valid); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr got %h want 00000000", imem_req_addr); end
        tick(); rst = 1'b0; #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            errors++; $display("FAIL first_req got v=%b a=%h want v=1 a=00000000", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_throughput();
        logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        int waited = 0;
        #1;
        while (inst_valid !== 1'b1 && waited < 10) begin tick(); #1; waited++; end
        checks++; if (waited != 2) begin errors++; $display("FAIL tput_first_latency got %0d want 2", waited); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (inst_valid !== 1'b1 || inst_pc !== exp_pc[k] || inst_data !== ~exp_pc[k]) begin
                errors++; $display("FAIL tput_seq%0d got v=%b pc=%h d=%h want v=1 pc=%h d=%h",
                                   k, inst_valid, inst_pc, inst_data, exp_pc[k], ~exp_pc[k]); end
            tick(); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        int base_req, base_log;
        lat = 1; inst_ready = 1'b0;
        pulse_reset();
        base_req = n_req; base_log = n_log;
        repeat (10) tick();
        #1;
        checks++; if (n_req - base_req != 4) begin errors++; $display("FAIL bp_req_count got %0d want 4", n_req - base_req); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid got %b want 0", imem_req_valid); end
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
            errors++; $display("FAIL bp_head got v=%b pc=%h want v=1 pc=00000000", inst_valid, inst_pc); end
        inst_ready = 1'b1;
        repeat (8) tick();
        #1;
        checks++; if (n_log - base_log < 5) begin errors++; $display("FAIL bp_drain_count got %0d want >=5", n_log - base_log); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (log_pc[8'(base_log + k)] !== exp_pc[k] || log_data[8'(base_log + k)] !== ~exp_pc[k]) begin
                errors++; $display("FAIL bp_drain%0d got pc=%h d=%h want pc=%h", k,
                                   log_pc[8'(base_log + k)], log_data[8'(base_log + k)], exp_pc[k]); end
        end
    endtask

    task automatic test_redirect_inflight();
        int base_log, waited;
        lat = 3; inst_ready = 1'b1;
        pulse_reset();
        repeat (3) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
        checks++; if (imem_rsp_valid !== 1'b1) begin errors++; $display("FAIL rd3_rsp_coincide got %b want 1", imem_rsp_valid); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rd3_req_valid got %b want 0", imem_req_valid); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rd3_inst_valid got %b want 0", inst_valid); end
        base_log = n_log;
        tick(); redirect_valid = 1'b0; #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
            errors++; $display("FAIL rd3_target_req got v=%b a=%h want v=1 a=00000100", imem_req_valid, imem_req_addr); end
        waited = 1;
        while (inst_valid !== 1'b1 && waited < 20) begin tick(); #1; waited++; end
        checks++; if (waited != 5) begin errors++; $display("FAIL rd3_latency got %0d want 5", waited); end
        checks++; if (inst_pc !== 32'h100 || inst_data !== ~32'h100) begin
            errors++; $display("FAIL rd3_first got pc=%h d=%h want pc=00000100 d=fffffeff", inst_pc, inst_data); end
        repeat (3) tick(); #1;
        checks++; if (log_pc[8'(base_log)] !== 32'h100 || log_pc[8'(base_log + 1)] !== 32'h104
                      || log_data[8'(base_log + 1)] !== ~32'h104) begin
            errors++; $display("FAIL rd3_log got %h %h want 00000100 00000104",
                               log_pc[8'(base_log)], log_pc[8'(base_log + 1)]); end
    endtask

    task automatic test_redirect_same_cycle();
        int base_log, waited;
        lat = 1; inst_ready = 1'b1;
        pulse_reset();
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
        checks++; if (imem_rsp_valid !== 1'b1) begin errors++; $display("FAIL rdsc_rsp_coincide got %b want 1", imem_rsp_valid); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rdsc_inst_valid got %b want 0", inst_valid); end
        base_log = n_log;
        tick(); redirect_valid = 1'b0; #1;
        waited = 1;
        while (inst_valid !== 1'b1 && waited < 20) begin tick(); #1; waited++; end
        checks++; if (waited != 3) begin errors++; $display("FAIL rdsc_latency got %0d want 3", waited); end
        checks++; if (inst_pc !== 32'h40 || inst_data !== ~32'h40) begin
            errors++; $display("FAIL rdsc_first got pc=%h d=%h want pc=00000040", inst_pc, inst_data); end
        tick(); #1;
        checks++; if (n_log - base_log < 1 || log_pc[8'(base_log)] !== 32'h40) begin
            errors++; $display("FAIL rdsc_log got n=%0d pc=%h want pc=00000040", n_log - base_log, log_pc[8'(base_log)]); end
    endtask

    task automatic test_align_wrap();
        logic [31:0] exp_pc [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        int base_log;
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
        tick(); redirect_valid = 1'b0; #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
            errors++; $display("FAIL align_req got v=%b a=%h want v=1 a=00000200", imem_req_valid, imem_req_addr); end
        tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        base_log = n_log;
        tick(); redirect_valid = 1'b0;
        repeat (8) tick();
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (log_pc[8'(base_log + k)] !== exp_pc[k] || log_data[8'(base_log + k)] !== ~exp_pc[k]) begin
                errors++; $display("FAIL wrap%0d got pc=%h d=%h want pc=%h", k,
                                   log_pc[8'(base_log + k)], log_data[8'(base_log + k)], exp_pc[k]); end
        end
    endtask

    task automatic test_reset_midop();
        lat = 3; inst_ready = 1'b0;
        pulse_reset();
        repeat (5) tick();
        #1;
        checks++; if (inst_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_pre got iv=%b rv=%b want iv=1 rv=0", inst_valid, imem_req_valid); end
        rst = 1'b1; #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL midrst_req_in_rst got %b want 0", imem_req_valid); end
        tick(); #1;
        checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_post got iv=%b rv=%b want 0 0", inst_valid, imem_req_valid); end
        tick(); rst = 1'b0; #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || imem_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_restart got rv=%b a=%h rsp=%b want rv=1 a=00000000 rsp=0",
                               imem_req_valid, imem_req_addr, imem_rsp_valid); end
    endtask

    initial begin
        test_reset();
        test_throughput();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_same_cycle();
        test_align_wrap();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
